// File: rtl/fetch_pkg.sv
// fetch_pkg: definitions shared by fetch, hazard control and decode.
//   fetch_state_e : fetch FSM encoding (RUN / HOLD / FLUSH)
//   NOP_INSTR     : instruction word injected on reset / flush
//   opcode field  : instr[15:13], with RTYPE and BEQ opcodes
//   sat_inc16     : 16-bit saturating increment used by the perf counters
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HOLD  = 2'd1,
    ST_FLUSH = 2'd2
  } fetch_state_e;

  localparam logic [15:0] NOP_INSTR = 16'h0000;

  localparam int OPC_HI = 15;
  localparam int OPC_LO = 13;

  typedef enum logic [2:0] {
    OPC_RTYPE = 3'd0,
    OPC_BEQ   = 3'd2
  } opcode_e;

  function automatic logic [2:0] opcode_of(input logic [15:0] instr);
    return instr[OPC_HI:OPC_LO];
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: fetch-stage bus (instruction memory, hazard-control inputs,
// IF/ID outputs and perf counters).
//   master : the fetch stage (drives imem_addr, IFID*, counters)
//   slave  : the environment (drives PCStall, MP, branch_target, imem_data)
interface fetch_stage_if #(
  parameter int PC_W = 16
) ();
  logic            PCStall;
  logic            MP;
  logic [PC_W-1:0] branch_target;
  logic [15:0]     imem_data;
  logic [PC_W-1:0] imem_addr;
  logic [15:0]     IFID;
  logic [PC_W-1:0] IFID_pc;
  logic            IFID_valid;
  logic [15:0]     stall_cnt;
  logic [15:0]     flush_cnt;

  modport master (
    input  PCStall, MP, branch_target, imem_data,
    output imem_addr, IFID, IFID_pc, IFID_valid, stall_cnt, flush_cnt
  );

  modport slave (
    output PCStall, MP, branch_target, imem_data,
    input  imem_addr, IFID, IFID_pc, IFID_valid, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/fetch_stage_ifid_latch.sv
// ifid_latch: IF/ID pipeline register (instruction, PC+1, valid).
//   clk_i, rst_i : clock, synchronous active-high reset (-> NOP, pc 0, invalid)
//   load_i       : capture instr_i / pc_i and mark valid
//   flush_i      : replace instruction with NOP and mark invalid (pc kept)
//   neither      : hold
//   instr_o, pc_o, valid_o : latch contents
module ifid_latch #(
  parameter int          PC_W = 16,
  parameter logic [15:0] NOP  = 16'h0000
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            load_i,
  input  logic            flush_i,
  input  logic [15:0]     instr_i,
  input  logic [PC_W-1:0] pc_i,
  output logic [15:0]     instr_o,
  output logic [PC_W-1:0] pc_o,
  output logic            valid_o
);

  logic [15:0]     instr_q, instr_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            valid_q, valid_d;

  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    if (load_i) begin
      instr_d = instr_i;
      pc_d    = pc_i;
      valid_d = 1'b1;
    end else if (flush_i) begin
      instr_d = NOP;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      instr_q <= NOP;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end

  assign instr_o = instr_q;
  assign pc_o    = pc_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch + IF/ID latch, predict-not-taken.
//   clock, reset : single clock, synchronous active-high reset
//   bus (master) : PCStall / MP / branch_target / imem_data in;
//                  imem_addr (= PC), IFID, IFID_pc, IFID_valid, stall_cnt, flush_cnt out
// Per-cycle priority: reset > MP > flush in progress > PCStall > fetch.
// An MP injects FLUSH_CYC NOP bubbles in total (the MP cycle plus FLUSH_CYC-1
// cycles in FLUSH), so the target instruction reaches IFID FLUSH_CYC+1 edges
// after the MP cycle's edge is counted as the first.
// Optional feature macro: FETCH_PERF_EN builds saturating stall/flush counters;
// without it both counter outputs are tied to zero.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int              PC_W      = 16,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter logic [15:0]     NOP       = 16'h0000,
  parameter int              FLUSH_CYC = 1
) (
  input logic           clock,
  input logic           reset,
  fetch_stage_if.master bus
);

  // Bubbles still to insert after the MP cycle itself.
  localparam logic [1:0] EXTRA_BUB = 2'(FLUSH_CYC - 1);

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [1:0]      bcnt_q, bcnt_d;
  logic [PC_W-1:0] pc_plus1;
  logic            lat_load, lat_flush;
  logic            stall_ev, flush_ev;

  assign pc_plus1 = pc_q + PC_W'(1);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    bcnt_d    = bcnt_q;
    lat_load  = 1'b0;
    lat_flush = 1'b0;
    stall_ev  = 1'b0;
    flush_ev  = 1'b0;
    if (bus.MP) begin
      // Redirect wins over stall and over an in-progress flush (restart).
      pc_d      = bus.branch_target;
      lat_flush = 1'b1;
      flush_ev  = 1'b1;
      bcnt_d    = EXTRA_BUB;
      state_d   = (FLUSH_CYC > 1) ? ST_FLUSH : ST_RUN;
    end else begin
      case (state_q)
        ST_FLUSH: begin
          // PCStall is ignored while bubbles drain; PC sits on the target.
          lat_flush = 1'b1;
          bcnt_d    = bcnt_q - 2'd1;
          if (bcnt_q <= 2'd1) state_d = bus.PCStall ? ST_HOLD : ST_RUN;
        end
        default: begin
          // RUN and HOLD behave alike per cycle: the current PCStall decides
          // between hold and fetch, so HOLD resumes fetching the same cycle.
          if (bus.PCStall) begin
            state_d  = ST_HOLD;
            stall_ev = 1'b1;
          end else begin
            state_d  = ST_RUN;
            lat_load = 1'b1;
            pc_d     = pc_plus1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      bcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      bcnt_q  <= bcnt_d;
    end
  end

  assign bus.imem_addr = pc_q;

  ifid_latch #(
    .PC_W (PC_W),
    .NOP  (NOP)
  ) u_ifid (
    .clk_i   (clock),
    .rst_i   (reset),
    .load_i  (lat_load),
    .flush_i (lat_flush),
    .instr_i (bus.imem_data),
    .pc_i    (pc_plus1),
    .instr_o (bus.IFID),
    .pc_o    (bus.IFID_pc),
    .valid_o (bus.IFID_valid)
  );

`ifdef FETCH_PERF_EN
  logic [15:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_ev) stall_cnt_q <= sat_inc16(stall_cnt_q);
      if (flush_ev) flush_cnt_q <= sat_inc16(flush_cnt_q);
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;
`else
  logic unused_perf;
  assign unused_perf   = stall_ev ^ flush_ev;
  assign bus.stall_cnt = '0;
  assign bus.flush_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: two instances (FLUSH_CYC=1 and FLUSH_CYC=3) share
// stimulus. Directed table for the single-bubble instance, a hand sequence for
// the three-bubble flush interrupted by reset, then random traffic, with every
// cycle also compared against a transaction-level model of both instances.
module tb_fetch_stage;

`ifdef FETCH_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk;
  logic rst, stall, mp;
  logic [15:0] bt;

  int vectors = 0;
  int miscompares = 0;

  fetch_stage_if #(.PC_W(16)) ifa ();
  fetch_stage_if #(.PC_W(16)) ifb ();

  function automatic logic [15:0] memf(input logic [15:0] a);
    return a ^ 16'h5A3C;
  endfunction

  assign ifa.PCStall = stall;  assign ifb.PCStall = stall;
  assign ifa.MP = mp;          assign ifb.MP = mp;
  assign ifa.branch_target = bt;
  assign ifb.branch_target = bt;
  assign ifa.imem_data = memf(ifa.imem_addr);
  assign ifb.imem_data = memf(ifb.imem_addr);

  fetch_stage #(.PC_W(16), .RESET_PC(16'h0), .NOP(16'h0), .FLUSH_CYC(1))
    dut_a (.clock(clk), .reset(rst), .bus(ifa));
  fetch_stage #(.PC_W(16), .RESET_PC(16'h0), .NOP(16'h0), .FLUSH_CYC(3))
    dut_b (.clock(clk), .reset(rst), .bus(ifb));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---- reference model: one entry per instance ----
  int          fcv [2] = '{1, 3};
  logic [15:0] m_pc [2], m_ifid [2], m_ifpc [2];
  logic        m_v [2];
  int          m_bub [2];
  int          m_sc [2], m_fc [2];

  function automatic int sat(input int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_pc[i] = 16'h0; m_ifid[i] = 16'h0; m_ifpc[i] = 16'h0; m_v[i] = 1'b0;
        m_bub[i] = 0; m_sc[i] = 0; m_fc[i] = 0;
      end else if (mp) begin
        m_pc[i] = bt; m_ifid[i] = 16'h0; m_v[i] = 1'b0;
        m_bub[i] = fcv[i] - 1; m_fc[i] = sat(m_fc[i]);
      end else if (m_bub[i] > 0) begin
        m_ifid[i] = 16'h0; m_v[i] = 1'b0; m_bub[i]--;
      end else if (stall) begin
        m_sc[i] = sat(m_sc[i]);
      end else begin
        m_ifid[i] = memf(m_pc[i]); m_ifpc[i] = m_pc[i] + 16'd1; m_v[i] = 1'b1;
        m_pc[i] = m_pc[i] + 16'd1;
      end
    end
  endtask

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    check("A addr", ifa.imem_addr, m_pc[0]);
    check("A ifid", ifa.IFID, m_ifid[0]);
    check("A ifpc", ifa.IFID_pc, m_ifpc[0]);
    check("A vld", 16'(ifa.IFID_valid), 16'(m_v[0]));
    check("A scnt", ifa.stall_cnt, PERF ? 16'(m_sc[0]) : 16'h0);
    check("A fcnt", ifa.flush_cnt, PERF ? 16'(m_fc[0]) : 16'h0);
    check("B addr", ifb.imem_addr, m_pc[1]);
    check("B ifid", ifb.IFID, m_ifid[1]);
    check("B ifpc", ifb.IFID_pc, m_ifpc[1]);
    check("B vld", 16'(ifb.IFID_valid), 16'(m_v[1]));
    check("B scnt", ifb.stall_cnt, PERF ? 16'(m_sc[1]) : 16'h0);
    check("B fcnt", ifb.flush_cnt, PERF ? 16'(m_fc[1]) : 16'h0);
  endtask

  // Inputs are changed at negedge; the model steps on posedge; compare at the next negedge.
  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_model();
  endtask

  task automatic drv(input logic r, input logic s, input logic m, input logic [15:0] b);
    rst = r; stall = s; mp = m; bt = b;
  endtask

  // ---- directed table for instance A (FLUSH_CYC=1) ----
  typedef struct {
    logic        rst, stall, mp;
    logic [15:0] bt;
    logic [15:0] e_addr, e_ifid, e_pc;
    logic        e_v;
  } vec_t;

  vec_t tbl [$];

  task automatic add(input logic r, input logic s, input logic m, input logic [15:0] b,
                     input logic [15:0] ea, input logic [15:0] ei,
                     input logic [15:0] ep, input logic ev);
    vec_t t;
    t.rst = r; t.stall = s; t.mp = m; t.bt = b;
    t.e_addr = ea; t.e_ifid = ei; t.e_pc = ep; t.e_v = ev;
    tbl.push_back(t);
  endtask

  initial begin
    drv(1'b1, 1'b0, 1'b0, 16'h0);

    // reset, then sequential fetch of addr-tagged words
    add(1, 0, 0, 16'h0,    16'h0000, 16'h0000,      16'h0000, 0);
    add(0, 0, 0, 16'h0,    16'h0001, memf(16'h0),   16'h0001, 1);
    add(0, 0, 0, 16'h0,    16'h0002, memf(16'h1),   16'h0002, 1);
    add(0, 0, 0, 16'h0,    16'h0003, memf(16'h2),   16'h0003, 1);
    add(0, 0, 0, 16'h0,    16'h0004, memf(16'h3),   16'h0004, 1);
    add(0, 0, 0, 16'h0,    16'h0005, memf(16'h4),   16'h0005, 1);
    // stall 3 cycles at PC=5
    add(0, 1, 0, 16'h0,    16'h0005, memf(16'h4),   16'h0005, 1);
    add(0, 1, 0, 16'h0,    16'h0005, memf(16'h4),   16'h0005, 1);
    add(0, 1, 0, 16'h0,    16'h0005, memf(16'h4),   16'h0005, 1);
    add(0, 0, 0, 16'h0,    16'h0006, memf(16'h5),   16'h0006, 1);
    add(0, 0, 0, 16'h0,    16'h0007, memf(16'h6),   16'h0007, 1);
    add(0, 0, 0, 16'h0,    16'h0008, memf(16'h7),   16'h0008, 1);
    add(0, 0, 0, 16'h0,    16'h0009, memf(16'h8),   16'h0009, 1);
    // mispredict at PC=9 to 0x40
    add(0, 0, 1, 16'h0040, 16'h0040, 16'h0000,      16'h0000, 0);
    add(0, 0, 0, 16'h0,    16'h0041, memf(16'h40),  16'h0041, 1);
    // MP together with PCStall: redirect taken, no hold afterwards
    add(0, 1, 1, 16'h0010, 16'h0010, 16'h0000,      16'h0000, 0);
    add(0, 0, 0, 16'h0,    16'h0011, memf(16'h10),  16'h0011, 1);
    // PC wrap at all-ones
    add(0, 0, 1, 16'hFFFF, 16'hFFFF, 16'h0000,      16'h0000, 0);
    add(0, 0, 0, 16'h0,    16'h0000, memf(16'hFFFF), 16'h0000, 1);
    add(0, 0, 0, 16'h0,    16'h0001, memf(16'h0),   16'h0001, 1);
    // reset beats MP and stall
    add(1, 1, 1, 16'h1234, 16'h0000, 16'h0000,      16'h0000, 0);
    add(0, 1, 0, 16'h0,    16'h0000, 16'h0000,      16'h0000, 0);
    add(0, 0, 0, 16'h0,    16'h0001, memf(16'h0),   16'h0001, 1);

    @(negedge clk);
    foreach (tbl[k]) begin
      drv(tbl[k].rst, tbl[k].stall, tbl[k].mp, tbl[k].bt);
      cyc();
      check($sformatf("tbl%0d addr", k), ifa.imem_addr, tbl[k].e_addr);
      check($sformatf("tbl%0d ifid", k), ifa.IFID, tbl[k].e_ifid);
      check($sformatf("tbl%0d vld", k), 16'(ifa.IFID_valid), 16'(tbl[k].e_v));
      if (tbl[k].e_v || tbl[k].rst)
        check($sformatf("tbl%0d ifpc", k), ifa.IFID_pc, tbl[k].e_pc);
    end

    // ---- instance B: 3-bubble flush interrupted by reset ----
    drv(0, 0, 1, 16'h0020); cyc();
    check("t6 bub1 addr", ifb.imem_addr, 16'h0020);
    check("t6 bub1 vld", 16'(ifb.IFID_valid), 16'h0);
    drv(0, 1, 0, 16'h0); cyc();
    check("t6 bub2 addr", ifb.imem_addr, 16'h0020);
    check("t6 bub2 vld", 16'(ifb.IFID_valid), 16'h0);
    drv(1, 0, 0, 16'h0); cyc();
    check("t6 rst addr", ifb.imem_addr, 16'h0000);
    check("t6 rst fcnt", ifb.flush_cnt, 16'h0);
    drv(0, 0, 0, 16'h0); cyc();
    check("t6 run ifid", ifb.IFID, memf(16'h0));
    check("t6 run addr", ifb.imem_addr, 16'h0001);
    drv(0, 0, 1, 16'h0030); cyc();
    check("t6 mp fcnt", ifb.flush_cnt, PERF ? 16'h1 : 16'h0);
    drv(0, 1, 0, 16'h0); cyc();
    check("t6 f1 vld", 16'(ifb.IFID_valid), 16'h0);
    drv(0, 0, 0, 16'h0); cyc();
    check("t6 f2 vld", 16'(ifb.IFID_valid), 16'h0);
    check("t6 f2 addr", ifb.imem_addr, 16'h0030);
    cyc();
    check("t6 tgt ifid", ifb.IFID, memf(16'h0030));
    check("t6 tgt ifpc", ifb.IFID_pc, 16'h0031);

    // ---- random traffic against the model ----
    for (int n = 0; n < 3000; n++) begin
      drv(($urandom_range(63) == 0), ($urandom_range(3) == 0),
          ($urandom_range(7) == 0), 16'($urandom));
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
